// File: rtl/shift_arbiter_pkg.sv
// Shared types and widths for the two-port shift arbiter.
package shift_arbiter_pkg;

  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/shift_arbiter_alu.sv
// Combinational 16-bit shifter/rotator shared by both request ports.
module alu
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  op_e                op_i,
  output logic [DATA_W-1:0]  y_o
);

  logic [2*DATA_W-1:0] rol_w;
  logic [2*DATA_W-1:0] ror_w;

  // Rotates shift a doubled copy so wrapped bits land in the kept half.
  always_comb begin
    rol_w = {a_i, a_i} << shamt_i;
    ror_w = {a_i, a_i} >> shamt_i;
    case (op_i)
      OP_LSL:  y_o = a_i << shamt_i;
      OP_LSR:  y_o = a_i >> shamt_i;
      OP_ROL:  y_o = rol_w[2*DATA_W-1:DATA_W];
      OP_ROR:  y_o = ror_w[DATA_W-1:0];
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter in front of one shared shift ALU; one transaction in flight.
// Define SHIFT_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
//
// Handshake: a request transfers on a rising edge where req_valid_i[k] and
// req_ready_o[k] are both high; a response transfers on an edge where
// rsp_valid_o[k] and rsp_ready_i[k] are both high. Valid never drops before
// its transfer, and payloads hold stable while valid is high.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [2*DATA_W-1:0]   req_data_i,
  input  logic [2*SHAMT_W-1:0]  req_shamt_i,
  input  logic [3:0]            req_op_i,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  busy_o,
  output logic                  grant_id_o,
  output state_e                dbg_state_o
);

  localparam logic CNT_LAST = (LAT == 2);

  state_e              state_q;
  logic                grant_q;
  logic [DATA_W-1:0]   data_q;
  logic [SHAMT_W-1:0]  shamt_q;
  op_e                 op_q;
  logic                cnt_q;
  logic [1:0]          rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic                win;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;
  logic [SHAMT_W-1:0]  sel_shamt;
  op_e                 sel_op;
  logic [DATA_W-1:0]   alu_y;

`ifdef SHIFT_ARB_RR_EN
  logic last_q;

  always_comb begin
    if (&req_valid_i) win = ~last_q;
    else              win = ~req_valid_i[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= win;
  end
`else
  assign win = ~req_valid_i[0];
`endif

  // rst_n gates ready so nothing looks acceptable while reset is held.
  assign req_ready_o = (state_q == IDLE && rst_n) ?
                       (req_valid_i & (win ? 2'b10 : 2'b01)) : 2'b00;
  assign accept      = |req_ready_o;

  assign sel_data  = win ? req_data_i[2*DATA_W-1:DATA_W]   : req_data_i[DATA_W-1:0];
  assign sel_shamt = win ? req_shamt_i[2*SHAMT_W-1:SHAMT_W] : req_shamt_i[SHAMT_W-1:0];
  assign sel_op    = op_e'(win ? req_op_i[3:2] : req_op_i[1:0]);

  alu u_alu (
    .a_i     (data_q),
    .shamt_i (shamt_q),
    .op_i    (op_q),
    .y_o     (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      data_q      <= '0;
      shamt_q     <= '0;
      op_q        <= OP_LSL;
      cnt_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= EXEC;
            grant_q <= win;
            data_q  <= sel_data;
            shamt_q <= sel_shamt;
            op_q    <= sel_op;
            cnt_q   <= 1'b0;
          end
        end
        EXEC: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            rsp_data_q  <= alu_y;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i[grant_q]) begin
            state_q     <= IDLE;
            rsp_valid_q <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_id_o  = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: LAT=1 instance plus a LAT=2 instance.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_shamt;
  logic [3:0]  req_op;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready,  req_ready2;
  logic [1:0]  rsp_valid,  rsp_valid2;
  logic [15:0] rsp_data,   rsp_data2;
  logic        busy,       busy2;
  logic        grant_id,   grant_id2;
  state_e      dbg_state,  dbg_state2;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  shift_arbiter #(.LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .req_shamt_i(req_shamt), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .busy_o(busy), .grant_id_o(grant_id), .dbg_state_o(dbg_state)
  );

  shift_arbiter #(.LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready2),
    .req_data_i(req_data), .req_shamt_i(req_shamt), .req_op_i(req_op),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data2),
    .busy_o(busy2), .grant_id_o(grant_id2), .dbg_state_o(dbg_state2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model and drivers ----------------
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input int s, input int op);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      case (op)
        0: r[i] = (i >= s) ? d[i-s] : 1'b0;
        1: r[i] = (i + s < 16) ? d[i+s] : 1'b0;
        2: r[i] = d[(i - s + 16) % 16];
        default: r[i] = d[(i + s) % 16];
      endcase
    end
    return r;
  endfunction

  task automatic set_req(input int p, input logic [15:0] d, input logic [3:0] s,
                         input logic [1:0] o);
    if (p == 1) begin
      req_data[31:16] = d; req_shamt[7:4] = s; req_op[3:2] = o;
    end else begin
      req_data[15:0] = d; req_shamt[3:0] = s; req_op[1:0] = o;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
    req_data = '0; req_shamt = '0; req_op = '0;
    #2;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, busy, grant_id} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h busy=%b gnt=%b, want all 0",
               req_ready, rsp_valid, rsp_data, busy, grant_id);
    end
    n_checks++;
    if ({req_ready2, rsp_valid2, rsp_data2, busy2, grant_id2} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_outputs_lat2: got rdy=%b vld=%b data=%h busy=%b gnt=%b, want all 0",
               req_ready2, rsp_valid2, rsp_data2, busy2, grant_id2);
    end
    #10;
    req_valid = 2'b00;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_rol_port0();
    rsp_ready = 2'b11;
    set_req(0, 16'h8001, 4'd1, 2'b10);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++; $display("FAIL rol_ready: got %b want 01", req_ready);
    end
    exp_q.push_back({1'b0, 16'h0003});
    cyc();
    req_valid = 2'b00;
    set_req(0, 16'hDEAD, 4'd7, 2'b00);
    n_checks++;
    if ({busy, grant_id, req_ready, rsp_valid} !== {1'b1, 1'b0, 2'b00, 2'b00}) begin
      n_errors++;
      $display("FAIL rol_exec: got busy=%b gnt=%b rdy=%b vld=%b want 1 0 00 00",
               busy, grant_id, req_ready, rsp_valid);
    end
    cyc();
    n_checks++;
    if ({rsp_valid, grant_id, rsp_data} !== {2'b01, exp_q[0]}) begin
      n_errors++;
      $display("FAIL rol_resp: got vld=%b gnt=%b data=%h want 01 %b %h",
               rsp_valid, grant_id, rsp_data, exp_q[0][16], exp_q[0][15:0]);
    end
    void'(exp_q.pop_front());
    cyc();
    n_checks++;
    if ({busy, rsp_valid} !== 3'b000) begin
      n_errors++; $display("FAIL rol_idle: got busy=%b vld=%b want 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_hold_port1();
    rsp_ready = 2'b00;
    set_req(1, 16'h1234, 4'd4, 2'b11);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_errors++; $display("FAIL hold_ready: got %b want 10", req_ready);
    end
    exp_q.push_back({1'b1, ref_shift(16'h1234, 4, 3)});
    cyc();
    req_valid = 2'b11;
    set_req(1, 16'hFFFF, 4'd9, 2'b00);
    cyc();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i % 2 == 0) ? 2'b01 : 2'b00;
      n_checks++;
      if ({rsp_valid, grant_id, rsp_data} !== {2'b10, exp_q[0]} || req_ready !== 2'b00) begin
        n_errors++;
        $display("FAIL hold_stable[%0d]: got vld=%b gnt=%b data=%h rdy=%b want 10 1 %h 00",
                 i, rsp_valid, grant_id, rsp_data, req_ready, exp_q[0][15:0]);
      end
      cyc();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b10;
    void'(exp_q.pop_front());
    cyc();
    n_checks++;
    if ({busy, rsp_valid} !== 3'b000) begin
      n_errors++; $display("FAIL hold_done: got busy=%b vld=%b want 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_arbitration();
    int n_acc = 0;
    int n_rsp = 0;
    int p;
    rsp_ready = 2'b11;
    set_req(0, 16'h8000, 4'd15, 2'b01);
    set_req(1, 16'h8001, 4'd1, 2'b00);
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 60 && n_rsp < 4; c++) begin
      if (req_ready != 2'b00) begin
`ifdef SHIFT_ARB_RR_EN
        p = n_acc % 2;
`else
        p = 0;
`endif
        n_checks++;
        if (req_ready !== ((p == 1) ? 2'b10 : 2'b01)) begin
          n_errors++; $display("FAIL arb_grant[%0d]: got rdy=%b want port %0d", n_acc, req_ready, p);
        end
        exp_q.push_back({p[0], (p == 1) ? ref_shift(16'h8001, 1, 0) : ref_shift(16'h8000, 15, 1)});
        n_acc++;
      end
      if (rsp_valid != 2'b00) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++; $display("FAIL arb_resp[%0d]: got unexpected vld=%b want none", n_rsp, rsp_valid);
        end else begin
          if ({grant_id, rsp_data} !== exp_q[0] ||
              rsp_valid !== (exp_q[0][16] ? 2'b10 : 2'b01)) begin
            n_errors++;
            $display("FAIL arb_resp[%0d]: got vld=%b gnt=%b data=%h want port %b data %h",
                     n_rsp, rsp_valid, grant_id, rsp_data, exp_q[0][16], exp_q[0][15:0]);
          end
          void'(exp_q.pop_front());
        end
        n_rsp++;
      end
      if (n_rsp < 4) cyc();
    end
    n_checks++;
    if (n_rsp < 4) begin
      n_errors++; $display("FAIL arb_timeout: got %0d responses want 4", n_rsp);
    end
    req_valid = 2'b00;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL arb_drain: got busy=%b queue=%0d want 0 0", busy, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 2'b11;
    set_req(0, 16'h00F0, 4'd2, 2'b00);
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_data, busy, grant_id, dbg_state} !== {21'd0, IDLE}) begin
      n_errors++;
      $display("FAIL midreset_async: got rdy=%b vld=%b data=%h busy=%b gnt=%b st=%0d want all 0",
               req_ready, rsp_valid, rsp_data, busy, grant_id, dbg_state);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        n_errors++; $display("FAIL midreset_dropped[%0d]: got vld=%b busy=%b want 00 0", i, rsp_valid, busy);
      end
    end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++; $display("FAIL midreset_pointer: got rdy=%b want 01", req_ready);
    end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_lat2();
    rsp_ready = 2'b11;
    set_req(0, 16'hFFFF, 4'd0, 2'b00);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready2 !== 2'b01) begin
      n_errors++; $display("FAIL lat2_ready: got %b want 01", req_ready2);
    end
    exp_q.push_back({1'b0, ref_shift(16'hFFFF, 0, 0)});
    cyc();
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (busy2 !== 1'b1 || rsp_valid2 !== 2'b00) begin
        n_errors++; $display("FAIL lat2_exec[%0d]: got busy=%b vld=%b want 1 00", i, busy2, rsp_valid2);
      end
      cyc();
    end
    n_checks++;
    if ({rsp_valid2, grant_id2, rsp_data2} !== {2'b01, exp_q[0]} || busy2 !== 1'b1) begin
      n_errors++;
      $display("FAIL lat2_resp: got vld=%b gnt=%b data=%h busy=%b want 01 0 %h 1",
               rsp_valid2, grant_id2, rsp_data2, busy2, exp_q[0][15:0]);
    end
    void'(exp_q.pop_front());
    cyc();
    n_checks++;
    if (busy2 !== 1'b0 || rsp_valid2 !== 2'b00) begin
      n_errors++; $display("FAIL lat2_done: got busy=%b vld=%b want 0 00", busy2, rsp_valid2);
    end
  endtask

  task automatic test_random();
    int p;
    logic [15:0] d;
    logic [3:0] s;
    logic [1:0] o;
    logic done;
    for (int n = 0; n < 10; n++) begin
      p = $urandom_range(0, 1);
      d = 16'($urandom);
      s = 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      rsp_ready = 2'b00;
      set_req(p, d, s, o);
      req_valid = (p == 1) ? 2'b10 : 2'b01;
      #1;
      n_checks++;
      if (req_ready !== req_valid) begin
        n_errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, req_ready, req_valid);
      end
      exp_q.push_back({p[0], ref_shift(d, int'(s), int'(o))});
      cyc();
      req_valid = 2'b00;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
        rsp_ready = 2'($urandom_range(0, 3));
        if (rsp_valid != 2'b00) begin
          n_checks++;
          if ({grant_id, rsp_data} !== exp_q[0] || rsp_valid !== ((p == 1) ? 2'b10 : 2'b01)) begin
            n_errors++;
            $display("FAIL rand_resp[%0d]: got vld=%b gnt=%b data=%h want port %0d data %h",
                     n, rsp_valid, grant_id, rsp_data, p, exp_q[0][15:0]);
          end
          if (rsp_ready[p]) begin
            void'(exp_q.pop_front());
            done = 1'b1;
          end
        end
        cyc();
      end
      n_checks++;
      if (!done || busy !== 1'b0) begin
        n_errors++; $display("FAIL rand_complete[%0d]: got done=%b busy=%b want 1 0", n, done, busy);
        exp_q.delete();
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rol_port0();
    test_hold_port1();
    test_arbitration();
    test_reset_mid();
    test_lat2();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
